mux_scanout: RTL and testbench
==============================

Name: mux_scanout

Overview:
- Read-side sequencer for the double-buffered register mux.
- Each frame: pulses read_latch so the mux swaps in any completed write buffer, walks read_addr over all num_reg entries, and serialises every word MSB-first onto a shift-register-style output (sclk/sdata/slatch).
- Sits between the mux read port and the off-chip serial driver chain.

Parameters:
- width, 16, word width; must match the mux.
- num_reg, 3, number of entries per frame; must be >= 2.
- clk_div, 2, clk cycles per sclk half-period; must be >= 1.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  run frames back-to-back while high.
- read_addr  out  $clog2(num_reg)  mux read address.
- read_data  in  width  mux read data; valid the cycle after read_addr is presented.
- read_latch  out  1  one-cycle pulse to the mux at frame start.
- sclk  out  1  serial clock; data changes on the low phase.
- sdata  out  1  serial data, MSB of entry 0 first.
- slatch  out  1  output-register strobe at frame end.
- busy  out  1  high while a frame is in progress.
- frame_done  out  1  one-cycle pulse on the last frame cycle.

Behaviour:
- Reset, asynchronous while rst_n=0:
  - state=IDLE, index=0.
  - All outputs 0, including read_addr, sclk, sdata, slatch, busy and frame_done.
  - Reset mid-frame aborts immediately; slatch is not asserted for the aborted frame.
- FSM states: IDLE, LATCH, FETCH, LOAD, SHIFT, STROBE.
- IDLE: outputs idle (0). If enable=1, go to LATCH next cycle.
- LATCH, 1 cycle: read_latch=1, read_addr=0, busy=1. Next state FETCH with index=0.
- FETCH, 1 cycle: read_addr=index. Next state LOAD.
- LOAD, 1 cycle:
  - read_addr still equals index.
  - Shift register <= read_data.
  - Bit counter <= width-1.
  - Next state SHIFT.
- SHIFT, width*2*clk_div cycles:
  - Per bit: clk_div cycles with sclk=0, then clk_div cycles with sclk=1.
  - sdata = current MSB, stable for the whole bit.
  - Shift left at the end of the high phase.
  - After the last bit: sclk=0; if index=num_reg-1 go to STROBE, else index+1 and go to FETCH.
- STROBE, clk_div cycles:
  - slatch=1, sclk=0.
  - frame_done=1 on the final STROBE cycle only.
  - Next state is LATCH if enable=1, otherwise IDLE.
- Frame length = 1 + num_reg*(2 + 2*clk_div*width) + clk_div cycles.
- busy is 1 in every non-IDLE state.
- enable is sampled only in IDLE and on the final STROBE cycle. Deasserting it mid-frame does not truncate the frame.
- read_latch is issued exactly once per frame and never outside LATCH. Whether the mux swaps depends only on its own write_done history.
- Between words sdata holds the last bit shifted out. It is 0 in IDLE.
- Counters are sized to the parameters. The index never exceeds num_reg-1; no wrap beyond that.

Test Plan:
- Reset value: hold rst_n=0 for 5 cycles, then release with enable=0 -> all outputs 0 and state stays IDLE for 20 cycles.
- Single frame (width=16, num_reg=3, clk_div=2):
  - Stimulus: mux holds entries 0xA5A5, 0x0001, 0x8000; enable pulsed high for 1 cycle.
  - Required: read_latch pulses once.
  - Required: 48 sclk rising edges, with sdata sampled on them equal to A5A5,0001,8000 MSB-first.
  - Required: slatch high for 2 cycles; frame_done on cycle 201 after LATCH; busy high for exactly 201 cycles.
- Buffer swap ordering: writer completes a frame of 0x1234 (write_done) while scanout is mid-frame -> current frame still shows the old data; next frame's first word is 0x1234.
- Back-to-back: hold enable=1 -> LATCH follows STROBE with no IDLE cycle; read_latch pulses are exactly 201 cycles apart.
- Enable drop: deassert enable during word 1 -> frame completes with slatch and frame_done, then returns to IDLE; no further read_latch.
- Reset mid-frame: assert rst_n=0 during SHIFT of word 2 -> sclk, sdata, busy go 0 asynchronously; no slatch; after release with enable=1 a full fresh frame starts from entry 0.

Source files
------------

// File: rtl/mux_scanout.sv
// Read-side frame sequencer for the double-buffered register mux: latches the mux,
// fetches every entry in turn and serialises each word MSB-first onto sclk/sdata/slatch.
module mux_scanout #(
    parameter int unsigned width   = 16,
    parameter int unsigned num_reg = 3,
    parameter int unsigned clk_div = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    output logic [$clog2(num_reg)-1:0] read_addr,
    input  logic [width-1:0]           read_data,
    output logic                       read_latch,
    output logic                       sclk,
    output logic                       sdata,
    output logic                       slatch,
    output logic                       busy,
    output logic                       frame_done
);

    localparam int unsigned IdxW = $clog2(num_reg);
    localparam int unsigned DivW = (clk_div > 1) ? $clog2(clk_div) : 1;
    localparam int unsigned BitW = (width > 1) ? $clog2(width) : 1;

    localparam logic [IdxW-1:0] IdxLast = IdxW'(num_reg - 1);
    localparam logic [DivW-1:0] DivLast = DivW'(clk_div - 1);
    localparam logic [BitW-1:0] BitLast = BitW'(width - 1);

    if (num_reg < 2) begin : g_bad_num_reg
        $error("mux_scanout: num_reg must be >= 2");
    end
    if (clk_div < 1) begin : g_bad_clk_div
        $error("mux_scanout: clk_div must be >= 1");
    end

    typedef enum logic [2:0] {
        StIdle,
        StLatch,
        StFetch,
        StLoad,
        StShift,
        StStrobe
    } state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q;
    logic [DivW-1:0]   div_q;
    logic [BitW-1:0]   bit_q;
    logic [width-1:0]  sr_q;
    logic              phase_q;
    logic              last_q;

    logic div_last;
    logic bit_end;
    logic word_end;
    logic idx_last;

    assign div_last = (div_q == DivLast);
    // A bit ends on the final cycle of its high phase.
    assign bit_end  = (state_q == StShift) && phase_q && div_last;
    assign word_end = bit_end && (bit_q == '0);
    assign idx_last = (idx_q == IdxLast);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d = StLatch;
                end
            end
            StLatch: state_d = StFetch;
            StFetch: state_d = StLoad;
            StLoad:  state_d = StShift;
            StShift: begin
                if (word_end) begin
                    state_d = idx_last ? StStrobe : StFetch;
                end
            end
            StStrobe: begin
                if (div_last) begin
                    state_d = enable ? StLatch : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath: phase divider, bit counter, shift register and entry index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            sr_q    <= '0;
            phase_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    idx_q   <= '0;
                    div_q   <= '0;
                    phase_q <= 1'b0;
                    last_q  <= 1'b0;
                end
                StLatch: begin
                    idx_q   <= '0;
                    div_q   <= '0;
                    phase_q <= 1'b0;
                end
                StFetch: begin
                    div_q   <= '0;
                    phase_q <= 1'b0;
                end
                StLoad: begin
                    sr_q    <= read_data;
                    bit_q   <= BitLast;
                    div_q   <= '0;
                    phase_q <= 1'b0;
                end
                StShift: begin
                    div_q <= div_last ? '0 : div_q + DivW'(1);
                    if (div_last) begin
                        phase_q <= ~phase_q;
                    end
                    if (bit_end) begin
                        sr_q   <= {sr_q[width-2:0], 1'b0};
                        last_q <= sr_q[width-1];
                        if (bit_q != '0) begin
                            bit_q <= bit_q - BitW'(1);
                        end
                    end
                    if (word_end && !idx_last) begin
                        idx_q <= idx_q + IdxW'(1);
                    end
                end
                StStrobe: begin
                    div_q   <= div_last ? '0 : div_q + DivW'(1);
                    phase_q <= 1'b0;
                end
                default: begin
                    div_q   <= '0;
                    phase_q <= 1'b0;
                end
            endcase
        end
    end

    // Outputs decode from registered state only, so reset clears them asynchronously.
    always_comb begin
        read_addr  = '0;
        read_latch = 1'b0;
        sclk       = 1'b0;
        sdata      = 1'b0;
        slatch     = 1'b0;
        busy       = 1'b0;
        frame_done = 1'b0;
        unique case (state_q)
            StIdle: begin
            end
            StLatch: begin
                read_latch = 1'b1;
                busy       = 1'b1;
                sdata      = last_q;
            end
            StFetch, StLoad: begin
                read_addr = idx_q;
                busy      = 1'b1;
                sdata     = last_q;
            end
            StShift: begin
                read_addr = idx_q;
                busy      = 1'b1;
                sclk      = phase_q;
                sdata     = sr_q[width-1];
            end
            StStrobe: begin
                busy       = 1'b1;
                slatch     = 1'b1;
                sdata      = last_q;
                frame_done = div_last;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mux_scanout.sv
// Self-checking bench for mux_scanout with a behavioural double-buffered mux on its read port.
module tb_mux_scanout;

    localparam int W = 16;
    localparam int N = 3;
    localparam int D = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic [1:0]    read_addr;
    logic [W-1:0]  read_data;
    logic          read_latch, sclk, sdata, slatch, busy, frame_done;

    mux_scanout #(.width(W), .num_reg(N), .clk_div(D)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .read_addr  (read_addr),
        .read_data  (read_data),
        .read_latch (read_latch),
        .sclk       (sclk),
        .sdata      (sdata),
        .slatch     (slatch),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Behavioural mux: swap on read_latch only if a write frame completed.
    logic [W-1:0] wbuf [N];
    logic [W-1:0] rbuf [N];
    logic         wr_done = 1'b0;
    logic         pend = 1'b0;

    initial begin
        for (int i = 0; i < N; i++) begin
            wbuf[i] = '0;
            rbuf[i] = '0;
        end
        read_data = '0;
    end

    always @(posedge clk) begin
        if (read_latch && (pend || wr_done)) begin
            for (int i = 0; i < N; i++) rbuf[i] <= wbuf[i];
            pend <= 1'b0;
        end else if (wr_done) begin
            pend <= 1'b1;
        end
        read_data <= rbuf[read_addr];
    end

    // Monitor: monotonic counters sampled on the falling edge.
    int          cyc = 0;
    int          latch_cnt = 0, slatch_cnt = 0, busy_cnt = 0, idle_cnt = 0;
    int          done_cnt = 0, bit_cnt = 0, nz_cnt = 0;
    int          last_latch_cyc = 0, last_gap = 0, done_rel = 0;
    logic        prev_sclk = 1'b0;
    logic [63:0] stream = '0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (read_latch) begin
            latch_cnt = latch_cnt + 1;
            last_gap = cyc - last_latch_cyc;
            last_latch_cyc = cyc;
        end
        if (busy) busy_cnt = busy_cnt + 1;
        else idle_cnt = idle_cnt + 1;
        if (slatch) slatch_cnt = slatch_cnt + 1;
        if (frame_done) begin
            done_cnt = done_cnt + 1;
            done_rel = cyc - last_latch_cyc + 1;
        end
        if (sclk && !prev_sclk) begin
            stream = {stream[62:0], sdata};
            bit_cnt = bit_cnt + 1;
        end
        prev_sclk = sclk;
        if (read_latch || sclk || sdata || slatch || busy || frame_done || read_addr != 0)
            nz_cnt = nz_cnt + 1;
    end

    int n_vec = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic load_mux(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
        wbuf[0] = a;
        wbuf[1] = b;
        wbuf[2] = c;
        wr_done = 1'b1;
        tick();
        wr_done = 1'b0;
    endtask

    task automatic pulse_enable();
        enable = 1'b1;
        tick();
        enable = 1'b0;
    endtask

    task automatic wait_done(input string name, input int base, input int bound);
        int n;
        n = 0;
        while (done_cnt == base && n < bound) begin
            tick();
            n++;
        end
        if (done_cnt == base) chk({name, "_timeout"}, 0, 1);
    endtask

    typedef struct {
        logic [W-1:0] d0, d1, d2;
        logic [47:0]  exp_stream;
        int           exp_bits;
        int           exp_latch;
        int           exp_slatch;
        int           exp_busy;
        int           exp_done_rel;
    } vec_t;

    vec_t vecs [3];

    int b_latch, b_slatch, b_busy, b_done, b_bits, b_nz, b_idle;

    task automatic snap();
        b_latch = latch_cnt; b_slatch = slatch_cnt; b_busy = busy_cnt;
        b_done = done_cnt; b_bits = bit_cnt; b_nz = nz_cnt; b_idle = idle_cnt;
    endtask

    initial begin
        vecs[0] = '{16'hA5A5, 16'h0001, 16'h8000, 48'hA5A5_0001_8000, 48, 1, 2, 201, 201};
        vecs[1] = '{16'hFFFF, 16'h0000, 16'h5A5A, 48'hFFFF_0000_5A5A, 48, 1, 2, 201, 201};
        vecs[2] = '{16'h1234, 16'h8001, 16'h7FFE, 48'h1234_8001_7FFE, 48, 1, 2, 201, 201};

        // Reset: outputs idle during and after reset with enable low
        tick();
        chk("reset_outputs", {read_addr, read_latch, sclk, sdata, slatch, busy, frame_done}, 0);
        repeat (4) tick();
        rst_n = 1'b1;
        snap();
        repeat (20) tick();
        chk("idle_after_reset_nz", nz_cnt - b_nz, 0);
        chk("idle_after_reset_busy", busy_cnt - b_busy, 0);

        // Single frames from the table
        foreach (vecs[i]) begin
            load_mux(vecs[i].d0, vecs[i].d1, vecs[i].d2);
            repeat (2) tick();
            snap();
            pulse_enable();
            wait_done($sformatf("v%0d", i), b_done, 400);
            repeat (5) tick();
            chk($sformatf("v%0d_stream", i), stream[47:0], vecs[i].exp_stream);
            chk($sformatf("v%0d_bits", i), bit_cnt - b_bits, vecs[i].exp_bits);
            chk($sformatf("v%0d_read_latch", i), latch_cnt - b_latch, vecs[i].exp_latch);
            chk($sformatf("v%0d_slatch", i), slatch_cnt - b_slatch, vecs[i].exp_slatch);
            chk($sformatf("v%0d_busy", i), busy_cnt - b_busy, vecs[i].exp_busy);
            chk($sformatf("v%0d_done_rel", i), done_rel, vecs[i].exp_done_rel);
        end

        // Buffer swap ordering: write completes mid-frame, shows up only next frame
        snap();
        pulse_enable();
        repeat (50) tick();
        load_mux(16'h1234, 16'h1234, 16'h1234);
        wait_done("swap_old", b_done, 400);
        repeat (3) tick();
        chk("swap_current_frame_old", stream[47:0], 48'h1234_8001_7FFE);
        snap();
        pulse_enable();
        wait_done("swap_new", b_done, 400);
        repeat (3) tick();
        chk("swap_next_first_word", stream[47:32], 16'h1234);
        chk("swap_next_frame", stream[47:0], 48'h1234_1234_1234);

        // Back-to-back frames with enable held high
        snap();
        enable = 1'b1;
        for (int n = 0; n < 600 && latch_cnt - b_latch < 2; n++) begin
            tick();
            if (latch_cnt - b_latch == 1 && read_latch) b_idle = idle_cnt;
        end
        chk("b2b_two_latches", latch_cnt - b_latch, 2);
        chk("b2b_latch_gap", last_gap, 201);
        chk("b2b_no_idle", idle_cnt - b_idle, 0);

        // Enable drop during word 1 of the second frame
        snap();
        repeat (80) tick();
        enable = 1'b0;
        wait_done("drop", b_done, 400);
        tick();
        chk("drop_slatch", slatch_cnt - b_slatch, 2);
        chk("drop_frame_done", done_cnt - b_done, 1);
        snap();
        repeat (300) tick();
        chk("drop_no_more_latch", latch_cnt - b_latch, 0);
        chk("drop_idle_busy", busy_cnt - b_busy, 0);

        // Reset during SHIFT of word 2
        load_mux(16'h0F0F, 16'h3C3C, 16'hFFFF);
        repeat (2) tick();
        snap();
        pulse_enable();
        repeat (150) tick();
        for (int n = 0; n < 10 && !sclk; n++) tick();
        chk("rst_mid_pre", {busy, sclk, sdata, read_addr}, {3'b111, 2'd2});
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_async", {busy, sclk, sdata, slatch, read_latch}, 0);
        repeat (3) tick();
        chk("rst_mid_no_slatch", slatch_cnt - b_slatch, 0);
        chk("rst_mid_no_done", done_cnt - b_done, 0);
        rst_n = 1'b1;
        snap();
        pulse_enable();
        wait_done("rst_fresh", b_done, 400);
        repeat (3) tick();
        chk("rst_fresh_stream", stream[47:0], 48'h0F0F_3C3C_FFFF);
        chk("rst_fresh_latch", latch_cnt - b_latch, 1);
        chk("rst_fresh_busy", busy_cnt - b_busy, 201);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
